// File: rtl/fetch_line_buffer_if.sv
// Fetch line buffer bus: I-cache request/response, redirect and decode handshake.
// master = the line buffer, slave = the surrounding frontend / testbench.
interface fetch_line_buffer_if #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LINE_INSTR = 32
);
    logic                       flush_i;
    logic [XLEN-1:0]            redirect_pc_i;

    logic                       ic_req_valid_o;
    logic                       ic_req_ready_i;
    logic [XLEN-1:0]            ic_req_addr_o;

    logic                       ic_rsp_valid_i;
    logic [XLEN-1:0]            ic_rsp_pc_i;
    logic [LINE_INSTR*ILEN-1:0] ic_rsp_line_i;

    logic                       instr_valid_o;
    logic                       instr_ready_i;
    logic [ILEN-1:0]            instr_o;
    logic [XLEN-1:0]            instr_pc_o;

    modport master (
        input  flush_i,
        input  redirect_pc_i,
        output ic_req_valid_o,
        input  ic_req_ready_i,
        output ic_req_addr_o,
        input  ic_rsp_valid_i,
        input  ic_rsp_pc_i,
        input  ic_rsp_line_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output instr_pc_o
    );

    modport slave (
        output flush_i,
        output redirect_pc_i,
        input  ic_req_valid_o,
        output ic_req_ready_i,
        input  ic_req_addr_o,
        output ic_rsp_valid_i,
        output ic_rsp_pc_i,
        output ic_rsp_line_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  instr_pc_o
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// Frontend line buffer: fetches one I-cache line at a time and streams
// its instructions to decode; redirects flush it and restart fetch.
module fetch_line_buffer #(
    parameter int              XLEN       = 64,
    parameter int              ILEN       = 32,
    parameter int              LINE_INSTR = 32,
    parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    fetch_line_buffer_if.master    bus
);

    localparam int LINE_LEN = LINE_INSTR * ILEN;
    localparam int IDXW     = $clog2(LINE_INSTR);
    localparam int OFF      = IDXW + 2;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_SERVE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [LINE_LEN-1:0] line_q, line_d;

    logic [IDXW-1:0]     idx;
    logic [XLEN-1:0]     line_addr;
    logic [XLEN-1:0]     flush_pc;
    logic [ILEN-1:0]     cur_instr;
    logic                last;
    logic                req_valid;
    logic                req_fire;

    logic                req_valid_o;
    logic [XLEN-1:0]     req_addr_o;
    logic                instr_valid_o;
    logic [ILEN-1:0]     instr_o;
    logic [XLEN-1:0]     instr_pc_o;

    assign idx       = pc_q[OFF-1:2];
    assign line_addr = {pc_q[XLEN-1:OFF], {OFF{1'b0}}};
    assign flush_pc  = bus.redirect_pc_i & ~XLEN'(3);
    assign cur_instr = line_q[idx*ILEN +: ILEN];
    assign last      = &idx;

    // A discarded response is still owed while drop_q is set.
    assign req_valid = (state_q == S_REQ) && !drop_q;
    assign req_fire  = req_valid && bus.ic_req_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_REQ;
            pc_q    <= BOOT_PC;
            drop_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        line_d  = line_q;

        if (bus.ic_rsp_valid_i && drop_q) begin
            drop_d = 1'b0;
        end

        if (bus.flush_i) begin
            state_d = S_REQ;
            pc_d    = flush_pc;
            // A request already in flight must have its response swallowed.
            if ((state_q == S_WAIT && !bus.ic_rsp_valid_i) || req_fire) begin
                drop_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ic_rsp_valid_i) begin
                        line_d  = bus.ic_rsp_line_i;
                        state_d = S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (bus.instr_ready_i) begin
                        pc_d = pc_q + XLEN'(4);
                        if (last) begin
                            state_d = S_REQ;
                        end
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_comb begin
        req_valid_o   = 1'b0;
        req_addr_o    = '0;
        instr_valid_o = 1'b0;
        instr_o       = '0;
        instr_pc_o    = '0;
        if (rst_n_i) begin
            unique case (state_q)
                S_REQ: begin
                    req_valid_o = req_valid;
                    req_addr_o  = line_addr;
                end
                S_SERVE: begin
                    instr_valid_o = 1'b1;
                    instr_o       = cur_instr;
                    instr_pc_o    = pc_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ic_req_valid_o = req_valid_o;
    assign bus.ic_req_addr_o  = req_addr_o;
    assign bus.instr_valid_o  = instr_valid_o;
    assign bus.instr_o        = instr_o;
    assign bus.instr_pc_o     = instr_pc_o;

    a_rsp_addr: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (state_q == S_WAIT && bus.ic_rsp_valid_i)
            |-> (bus.ic_rsp_pc_i == line_addr)
    ) else $error("response line address differs from request");

    a_rsp_stray: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (bus.ic_rsp_valid_i && state_q != S_WAIT) |-> drop_q
    ) else $error("unexpected I-cache response");

    a_one_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (state_q == S_WAIT) |-> !req_valid
    ) else $error("second request while one is outstanding");

    a_hold: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (instr_valid_o && !bus.instr_ready_i && !bus.flush_i)
            |=> ($stable(instr_o) && $stable(instr_pc_o))
    ) else $error("instruction changed under backpressure");

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: a cycle table for request/flush/drop
// timing, then scoreboarded line streaming, stall, reset and redirect.
module tb_fetch_line_buffer;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int LINE_INSTR = 32;
    localparam int LINE_LEN   = LINE_INSTR * ILEN;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    typedef struct {
        bit              f;
        logic [XLEN-1:0] redir;
        bit              rr;
        bit              rv;
        logic [XLEN-1:0] rpc;
        bit              ir;
        bit              e_rv;
        logic [XLEN-1:0] e_addr;
        bit              e_iv;
        logic [ILEN-1:0] e_ins;
        logic [XLEN-1:0] e_pc;
    } vec_t;

    typedef struct {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   sb_en;
    exp_t sb_q[$];
    vec_t tbl[22];

    fetch_line_buffer_if #(
        .XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LINE_INSTR)
    ) bus ();

    fetch_line_buffer #(
        .XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LINE_INSTR),
        .BOOT_PC(64'h0)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm,
                                input logic [XLEN-1:0] got,
                                input logic [XLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endfunction

    function automatic logic [ILEN-1:0] mkword(input logic [XLEN-1:0] a,
                                               input int k);
        return 32'h1000 + a[31:0] + 32'(k);
    endfunction

    function automatic logic [LINE_LEN-1:0] mkline(input logic [XLEN-1:0] a);
        logic [LINE_LEN-1:0] l;
        l = '0;
        for (int k = 0; k < LINE_INSTR; k++) l[k*ILEN +: ILEN] = mkword(a, k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.flush_i        = 1'b0;
        bus.redirect_pc_i  = '0;
        bus.ic_req_ready_i = 1'b0;
        bus.ic_rsp_valid_i = 1'b0;
        bus.ic_rsp_pc_i    = '0;
        bus.ic_rsp_line_i  = '0;
        bus.instr_ready_i  = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rv"},   64'(bus.ic_req_valid_o), 64'h0);
        chk({nm, "_addr"}, bus.ic_req_addr_o,       64'h0);
        chk({nm, "_iv"},   64'(bus.instr_valid_o),  64'h0);
        chk({nm, "_ins"},  64'(bus.instr_o),        64'h0);
        chk({nm, "_pc"},   bus.instr_pc_o,          64'h0);
    endtask

    // Called at posedge+1; reset is pulsed between clock edges.
    task automatic do_reset(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_zero(nm);
        sb_q.delete();
        clr_in();
        #2 rst_n = 1'b1;
        tick();
        chk({nm, "_boot_rv"},   64'(bus.ic_req_valid_o), 64'h1);
        chk({nm, "_boot_addr"}, bus.ic_req_addr_o,       64'h0);
        chk({nm, "_boot_iv"},   64'(bus.instr_valid_o),  64'h0);
    endtask

    task automatic do_req(input logic [XLEN-1:0] a);
        int n;
        n = 0;
        while (!bus.ic_req_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid", 64'(bus.ic_req_valid_o), 64'h1);
        chk("req_addr",  bus.ic_req_addr_o,       a);
        bus.ic_req_ready_i = 1'b1;
        tick();
        bus.ic_req_ready_i = 1'b0;
        chk("req_wait", 64'(bus.ic_req_valid_o), 64'h0);
    endtask

    task automatic do_rsp(input logic [XLEN-1:0] a, input int s);
        for (int k = s; k < LINE_INSTR; k++)
            sb_q.push_back('{instr: mkword(a, k), pc: a + XLEN'(4 * k)});
        chk("rsp_pre_iv", 64'(bus.instr_valid_o), 64'h0);
        bus.ic_rsp_valid_i = 1'b1;
        bus.ic_rsp_pc_i    = a;
        bus.ic_rsp_line_i  = mkline(a);
        tick();
        bus.ic_rsp_valid_i = 1'b0;
        chk("rsp_lat_iv", 64'(bus.instr_valid_o), 64'h1);
    endtask

    always @(negedge clk) begin
        if (sb_en && rst_n && bus.instr_valid_o &&
            bus.instr_ready_i && !bus.flush_i) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h, want none",
                         bus.instr_pc_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr", 64'(bus.instr_o), 64'(e.instr));
                chk("sb_pc",    bus.instr_pc_o,   e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sb_en  = 1'b0;
        rst_n  = 1'b0;
        clr_in();

        tbl[0]  = '{F, 64'h0,   F, F, 64'h0,   F, T, 64'h0,   F, 32'h0,    64'h0};
        tbl[1]  = '{F, 64'h0,   T, F, 64'h0,   F, T, 64'h0,   F, 32'h0,    64'h0};
        tbl[2]  = '{F, 64'h0,   F, F, 64'h0,   F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[3]  = '{F, 64'h0,   F, T, 64'h0,   F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[4]  = '{F, 64'h0,   F, F, 64'h0,   F, F, 64'h0,   T, 32'h1000, 64'h0};
        tbl[5]  = '{T, 64'h400, F, F, 64'h0,   F, F, 64'h0,   T, 32'h1000, 64'h0};
        tbl[6]  = '{F, 64'h0,   T, F, 64'h0,   F, T, 64'h400, F, 32'h0,    64'h0};
        tbl[7]  = '{T, 64'h1F5, F, F, 64'h0,   F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[8]  = '{F, 64'h0,   T, F, 64'h0,   F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[9]  = '{F, 64'h0,   F, T, 64'h400, F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[10] = '{F, 64'h0,   T, F, 64'h0,   F, T, 64'h180, F, 32'h0,    64'h0};
        tbl[11] = '{F, 64'h0,   F, T, 64'h180, F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[12] = '{F, 64'h0,   F, F, 64'h0,   T, F, 64'h0,   T, 32'h119D, 64'h1F4};
        tbl[13] = '{F, 64'h0,   F, F, 64'h0,   T, F, 64'h0,   T, 32'h119E, 64'h1F8};
        tbl[14] = '{F, 64'h0,   F, F, 64'h0,   T, F, 64'h0,   T, 32'h119F, 64'h1FC};
        tbl[15] = '{F, 64'h0,   F, F, 64'h0,   F, T, 64'h200, F, 32'h0,    64'h0};
        tbl[16] = '{T, 64'h800, T, F, 64'h0,   F, T, 64'h200, F, 32'h0,    64'h0};
        tbl[17] = '{F, 64'h0,   F, F, 64'h0,   F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[18] = '{F, 64'h0,   F, T, 64'h200, F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[19] = '{F, 64'h0,   T, F, 64'h0,   F, T, 64'h800, F, 32'h0,    64'h0};
        tbl[20] = '{T, 64'hC00, F, T, 64'h800, F, F, 64'h0,   F, 32'h0,    64'h0};
        tbl[21] = '{F, 64'h0,   F, F, 64'h0,   F, T, 64'hC00, F, 32'h0,    64'h0};

        #3 chk_zero("in_reset");
        #9 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            bus.flush_i        = tbl[i].f;
            bus.redirect_pc_i  = tbl[i].redir;
            bus.ic_req_ready_i = tbl[i].rr;
            bus.ic_rsp_valid_i = tbl[i].rv;
            bus.ic_rsp_pc_i    = tbl[i].rpc;
            bus.ic_rsp_line_i  = tbl[i].rv ? mkline(tbl[i].rpc) : '0;
            bus.instr_ready_i  = tbl[i].ir;
            chk($sformatf("v%0d_rv", i), 64'(bus.ic_req_valid_o),
                64'(tbl[i].e_rv));
            if (tbl[i].e_rv)
                chk($sformatf("v%0d_addr", i), bus.ic_req_addr_o,
                    tbl[i].e_addr);
            chk($sformatf("v%0d_iv", i), 64'(bus.instr_valid_o),
                64'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("v%0d_ins", i), 64'(bus.instr_o),
                    64'(tbl[i].e_ins));
                chk($sformatf("v%0d_pc", i), bus.instr_pc_o, tbl[i].e_pc);
            end
            tick();
        end
        clr_in();

        sb_en = 1'b1;
        do_reset("rst_a");
        do_req(64'h0);
        do_rsp(64'h0, 0);
        bus.instr_ready_i = 1'b1;
        repeat (4) tick();
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_iv",  64'(bus.instr_valid_o), 64'h1);
            chk("stall_ins", 64'(bus.instr_o),       64'h1004);
            chk("stall_pc",  bus.instr_pc_o,         64'h10);
            tick();
        end
        bus.instr_ready_i = 1'b1;
        repeat (28) tick();
        bus.instr_ready_i = 1'b0;
        chk("line0_left", 64'(sb_q.size()),       64'h0);
        chk("cross_rv",   64'(bus.ic_req_valid_o), 64'h1);
        chk("cross_addr", bus.ic_req_addr_o,       64'h80);

        do_reset("rst_b");
        do_req(64'h0);
        do_rsp(64'h0, 0);
        bus.instr_ready_i = 1'b1;
        repeat (9) tick();
        bus.instr_ready_i = 1'b0;
        chk("mid_iv", 64'(bus.instr_valid_o), 64'h1);
        chk("mid_pc", bus.instr_pc_o,         64'h24);
        do_reset("rst_mid");

        do_req(64'h0);
        do_rsp(64'h0, 0);
        bus.instr_ready_i = 1'b1;
        repeat (2) tick();
        bus.flush_i       = 1'b1;
        bus.redirect_pc_i = 64'h40D;
        sb_q.delete();
        tick();
        bus.flush_i       = 1'b0;
        bus.instr_ready_i = 1'b0;
        chk("fl_iv",   64'(bus.instr_valid_o),  64'h0);
        chk("fl_rv",   64'(bus.ic_req_valid_o), 64'h1);
        chk("fl_addr", bus.ic_req_addr_o,       64'h400);
        do_req(64'h400);
        do_rsp(64'h400, 3);
        bus.instr_ready_i = 1'b1;
        repeat (29) tick();
        bus.instr_ready_i = 1'b0;
        chk("redir_left", 64'(sb_q.size()),       64'h0);
        chk("redir_rv",   64'(bus.ic_req_valid_o), 64'h1);
        chk("redir_addr", bus.ic_req_addr_o,       64'h480);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
